symbol_hist: RTL and testbench

- Upstream histogram stage of the Huffman datapath.
- Accepts a frame of gray-level symbols (legal values 1..6) and counts occurrences per symbol.
- After the last sample of the frame, presents the six final counts and issues a one-cycle start pulse to the ordering stage, which ranks the counts.
- Holds the counts frozen until the ordering stage acknowledges completion, then accepts the next frame.

---
 rtl/symbol_hist_if.sv | 31 +++
 rtl/symbol_hist.sv | 111 +++++++++++
 tb/tb_symbol_hist.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/symbol_hist_if.sv
// Stream, ordering-handshake and count bundle between the gray-level source,
// the histogram stage and the ordering stage.
interface symbol_hist_if #(
    parameter int unsigned CNT_W = 8
);
    logic             gray_valid;
    logic [7:0]       gray_data;
    logic             gray_ready;
    logic             ord_done;
    logic [CNT_W-1:0] CNT1;
    logic [CNT_W-1:0] CNT2;
    logic [CNT_W-1:0] CNT3;
    logic [CNT_W-1:0] CNT4;
    logic [CNT_W-1:0] CNT5;
    logic [CNT_W-1:0] CNT6;
    logic             start_order_flg;
    logic             busy;
    logic             err_sym;

    modport master (
        output gray_valid, gray_data, ord_done,
        input  gray_ready, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
               start_order_flg, busy, err_sym
    );

    modport slave (
        input  gray_valid, gray_data, ord_done,
        output gray_ready, CNT1, CNT2, CNT3, CNT4, CNT5, CNT6,
               start_order_flg, busy, err_sym
    );
endinterface

// File: rtl/symbol_hist.sv
// Per-frame occurrence counter for gray-level symbols 1..6; freezes the counts
// and pulses start_order_flg until the ordering stage acknowledges.
module symbol_hist #(
    parameter int unsigned FRAME_LEN = 100,
    parameter int unsigned CNT_W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    symbol_hist_if.slave  bus
);
    localparam int unsigned SC_W = $clog2(FRAME_LEN + 1);
    localparam logic [SC_W-1:0] LAST_M1 = SC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [SC_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] cnt_q [6];
    logic [CNT_W-1:0] cnt_d [6];
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             accept;
    logic             legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            cnt_q        <= '{default: '0};
            err_q        <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            start_q      <= start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        start_d      = 1'b0;
        accept       = bus.gray_valid && (state_q != DONE);
        legal        = (bus.gray_data >= 8'd1) && (bus.gray_data <= 8'd6);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d        = '{default: '0};
                    err_d        = 1'b0;
                    sample_cnt_d = SC_W'(1);
                    if (FRAME_LEN == 1) begin
                        state_d = DONE;
                        start_d = 1'b1;
                    end else begin
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    if (sample_cnt_q == LAST_M1) begin
                        state_d = DONE;
                        start_d = 1'b1;
                    end
                end
            end
            DONE: begin
                // The acknowledge is only honoured once the start pulse has retired.
                if (bus.ord_done && !start_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Sample application runs on top of the IDLE clear so the first sample counts.
        if (accept) begin
            if (!legal) begin
                err_d = 1'b1;
            end
            for (int unsigned i = 0; i < 6; i++) begin
                if (legal && (bus.gray_data == 8'(i + 1)) && (cnt_d[i] != '1)) begin
                    cnt_d[i] = cnt_d[i] + 1'b1;
                end
            end
        end
    end

    assign bus.gray_ready      = (state_q != DONE);
    assign bus.busy            = (state_q != IDLE);
    assign bus.start_order_flg = start_q;
    assign bus.err_sym         = err_q;
    assign bus.CNT1            = cnt_q[0];
    assign bus.CNT2            = cnt_q[1];
    assign bus.CNT3            = cnt_q[2];
    assign bus.CNT4            = cnt_q[3];
    assign bus.CNT5            = cnt_q[4];
    assign bus.CNT6            = cnt_q[5];
endmodule

// File: tb/tb_symbol_hist.sv
// Directed-plus-random bench for symbol_hist against a queue-based histogram model.
module tb_symbol_hist;
    localparam int FRAME_LEN = 100;
    localparam int CNT_W     = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    symbol_hist_if #(.CNT_W(CNT_W)) bus();

    symbol_hist #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int frame_q[$];
    int acc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int s);
        int c = 0;
        foreach (acc[i]) if (acc[i] == s && c < (1 << CNT_W) - 1) c++;
        return c;
    endfunction

    function automatic bit exp_err();
        foreach (acc[i]) if (acc[i] < 1 || acc[i] > 6) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [CNT_W-1:0] dut_cnt(input int s);
        case (s)
            1:       return bus.CNT1;
            2:       return bus.CNT2;
            3:       return bus.CNT3;
            4:       return bus.CNT4;
            5:       return bus.CNT5;
            default: return bus.CNT6;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        for (int s = 1; s <= 6; s++)
            chk($sformatf("%s_cnt%0d", tag, s), 32'(dut_cnt(s)), exp_cnt(s));
        chk({tag, "_err"}, 32'(bus.err_sym), 32'(exp_err()));
    endtask

    task automatic build_frame(input int n1, input int n2, input int n3,
                               input int n4, input int n5, input int n6);
        int n[6];
        n = '{n1, n2, n3, n4, n5, n6};
        frame_q.delete();
        for (int s = 0; s < 6; s++)
            for (int k = 0; k < n[s]; k++) frame_q.push_back(s + 1);
    endtask

    task automatic shuffle_frame();
        for (int i = frame_q.size() - 1; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i));
            t = frame_q[i];
            frame_q[i] = frame_q[j];
            frame_q[j] = t;
        end
    endtask

    // Sends the first n entries of frame_q with random bubbles (pct % chance each).
    task automatic run_frame(input int n, input int pct, input string tag);
        acc.delete();
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 20 && int'($urandom_range(99)) < pct; b++) begin
                bus.gray_valid = 1'b0;
                bus.gray_data  = 8'($urandom_range(255));
                tick();
                if (i > 0) chk({tag, "_bubble_start"}, 32'(bus.start_order_flg), 0);
            end
            bus.gray_valid = 1'b1;
            bus.gray_data  = 8'(frame_q[i]);
            tick();
            bus.gray_valid = 1'b0;
            acc.push_back(frame_q[i]);
            if (i == 0) check_counts({tag, "_first"});
            if (i == FRAME_LEN - 1) begin
                chk({tag, "_pulse"}, 32'(bus.start_order_flg), 1);
                chk({tag, "_done_ready"}, 32'(bus.gray_ready), 0);
                chk({tag, "_done_busy"}, 32'(bus.busy), 1);
                check_counts({tag, "_final"});
            end else begin
                chk({tag, "_mid_start"}, 32'(bus.start_order_flg), 0);
                chk({tag, "_mid_ready"}, 32'(bus.gray_ready), 1);
                chk({tag, "_mid_busy"}, 32'(bus.busy), 1);
            end
        end
    endtask

    // ord_done during the pulse cycle must be ignored.
    task automatic post_pulse(input string tag);
        bus.ord_done = 1'b1;
        tick();
        bus.ord_done = 1'b0;
        chk({tag, "_pulse_off"}, 32'(bus.start_order_flg), 0);
        chk({tag, "_early_ack_busy"}, 32'(bus.busy), 1);
        chk({tag, "_early_ack_ready"}, 32'(bus.gray_ready), 0);
    endtask

    task automatic ack(input string tag);
        bus.ord_done = 1'b1;
        tick();
        bus.ord_done = 1'b0;
        chk({tag, "_ack_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ack_ready"}, 32'(bus.gray_ready), 1);
        check_counts({tag, "_held"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum;
        bus.gray_valid = 1'b0;
        bus.gray_data  = 8'd0;
        bus.ord_done   = 1'b0;

        // Reset
        reset = 1'b1;
        tick();
        tick();
        acc.delete();
        check_counts("rst");
        chk("rst_ready", 32'(bus.gray_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_start", 32'(bus.start_order_flg), 0);
        reset = 1'b0;

        bus.ord_done = 1'b1;
        tick();
        bus.ord_done = 1'b0;
        chk("idle_ack_busy", 32'(bus.busy), 0);
        chk("idle_ack_ready", 32'(bus.gray_ready), 1);

        // Back-to-back frame
        build_frame(10, 20, 30, 15, 5, 20);
        shuffle_frame();
        run_frame(FRAME_LEN, 0, "s2");
        chk("s2_cnt1_abs", 32'(bus.CNT1), 10);
        chk("s2_cnt3_abs", 32'(bus.CNT3), 30);
        post_pulse("s2");
        ack("s2");

        // Same composition with bubbles
        shuffle_frame();
        run_frame(FRAME_LEN, 40, "s3");
        post_pulse("s3");
        ack("s3");

        // Frame with two illegal symbols
        build_frame(17, 17, 16, 16, 16, 16);
        frame_q.push_back(0);
        frame_q.push_back(7);
        shuffle_frame();
        run_frame(FRAME_LEN, 10, "s4");
        sum = 0;
        for (int s = 1; s <= 6; s++) sum += int'(dut_cnt(s));
        chk("s4_sum", sum, 98);
        chk("s4_err_abs", 32'(bus.err_sym), 1);

        // Backpressure in DONE
        for (int k = 0; k < 5; k++) begin
            bus.gray_valid = 1'b1;
            bus.gray_data  = 8'd2;
            tick();
            chk("s5_bp_cnt2", 32'(bus.CNT2), exp_cnt(2));
            chk("s5_bp_ready", 32'(bus.gray_ready), 0);
        end
        bus.gray_valid = 1'b0;
        check_counts("s5_bp");
        ack("s5");

        // Next frame starts with symbol 3, aborted by reset after 50 samples
        frame_q.delete();
        frame_q.push_back(3);
        for (int i = 1; i < 50; i++) frame_q.push_back(int'($urandom_range(7)));
        run_frame(50, 20, "s5n");
        chk("s5n_cnt3_first", 32'(bus.CNT3), exp_cnt(3));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc.delete();
        check_counts("s6_rst");
        chk("s6_rst_busy", 32'(bus.busy), 0);
        chk("s6_rst_ready", 32'(bus.gray_ready), 1);
        chk("s6_rst_start", 32'(bus.start_order_flg), 0);
        tick();
        chk("s6_after_start", 32'(bus.start_order_flg), 0);
        chk("s6_after_busy", 32'(bus.busy), 0);

        // Full random frame after the abort
        frame_q.delete();
        for (int i = 0; i < FRAME_LEN; i++) frame_q.push_back(int'($urandom_range(7)));
        run_frame(FRAME_LEN, 30, "s6");
        post_pulse("s6");
        ack("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
